seg7_scan_driver: RTL
=====================

# seg7_scan_driver

Time-multiplexed driver for the board's 8-digit common-anode 7-segment display. It sits directly downstream of the lab's nibble-producing logic: it accepts a 32-bit word (eight 4-bit hex nibbles) plus a per-digit enable mask, and scans the digits one at a time on `hex`/`hex_on`. The 16-glyph hex encoding is the same one the lab logic already uses. New values are double-buffered and take effect only at a frame boundary, so a frame is never torn.

## Interface
- `CLK_DIV`, default 100000: clock cycles per digit slot, minimum 2. At 100 MHz this gives 1 kHz per digit and 125 Hz per frame.
- `clk`  in  1  system clock; all state updates on its rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `data`  in  32  nibble i = `data[4i+3:4i]` is shown on digit i.
- `dig_en`  in  8  `dig_en[i]=1` enables digit i.
- `load`  in  1  single-cycle strobe; captures `data`/`dig_en` into the pending buffer.
- `busy`  out  1  high while a captured value is pending and not yet displayed.
- `frame_tick`  out  1  one-cycle pulse when a pending value is applied.
- `hex`  out  7  segments g..a, active-low.
- `hex_on`  out  8  digit anodes, active-low; bit i selects digit i.

## Operation
- State:
  - `div_cnt`: 0..CLK_DIV-1.
  - `idx`: 0..7.
  - Shown buffer: `shown[31:0]`, `shown_en[7:0]`.
  - Pending buffer: `pend[31:0]`, `pend_en[7:0]`, `pend_v`.
- Every cycle `div_cnt` increments. When `div_cnt==CLK_DIV-1`, `div_cnt` wraps to 0 and `idx` advances as `idx+1` mod 8.
- Frame boundary is the cycle where `idx==7` and `div_cnt==CLK_DIV-1`.
- `load=1`, not at a boundary: `pend<=data`, `pend_en<=dig_en`, `pend_v<=1`. A later load before the boundary overwrites the pending buffer; the latest load wins.
- At a boundary with `pend_v=1` and `load=0`:
  - `shown<=pend`, `shown_en<=pend_en`, `pend_v<=0`.
  - `frame_tick` pulses.
- At a boundary with `load=1`:
  - `data`/`dig_en` bypass the pending buffer straight into `shown`/`shown_en`.
  - `pend_v<=0`; `frame_tick` pulses.
  - Any older pending value is discarded.
- At a boundary with `pend_v=0` and `load=0`: the shown buffer is unchanged and there is no `frame_tick`.
- `busy` = `pend_v`.
- Segment decode of nibble n (g..a, active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Output function, evaluated on the state in cycle t:
  - Guard (`div_cnt==0`): `hex_on=8'hFF`, `hex=7'h7F`. This is anti-ghosting; the guard is the first cycle of each slot.
  - Active, with `shown_en[idx]=1`: `hex_on` = all ones except bit `idx`=0; `hex` = decode of nibble `idx` of `shown`.
  - Active, with `shown_en[idx]=0`: `hex_on=8'hFF`, `hex=7'h7F`.

## Timing
- Reset (`rst_n=0`, asynchronous, immediate):
  - `hex=7'h7F`, `hex_on=8'hFF`, `busy=0`, `frame_tick=0`.
  - `div_cnt=0`, `idx=0`.
  - `shown=0`, `shown_en=0`, `pend_v=0`.
  - The display stays blank until the first load is applied.
- `hex`, `hex_on`, `frame_tick` and `busy` are registered. The output in cycle t+1 reflects the state and decisions of cycle t.
- Slot length is CLK_DIV cycles: 1 guard cycle plus CLK_DIV-1 active cycles. Frame length is 8·CLK_DIV cycles.
- First boundary after reset is the edge ending cycle 8·CLK_DIV-1, counting the first cycle after reset release as cycle 0.
- Load-to-display latency:
  - `busy` rises the cycle after `load`.
  - Load-to-apply takes from 1 to 8·CLK_DIV cycles.
  - `frame_tick` and `busy` falling occur in the cycle after the boundary, which is also the digit-0 guard cycle.
  - Digit 0 of the new value appears one cycle after that.
- Reset asserted mid-frame or mid-pending: all state is cleared, pending data is lost, and there is no `frame_tick`.
- `load` held high for multiple cycles is treated as repeated loads; the last cycle's value wins.

## Test plan
All scenarios use CLK_DIV=4, so one frame is 32 cycles.
- Reset scenario:
  - Stimulus: `rst_n=0` for 3 cycles, then release with `load=0` for 64 cycles.
  - Required: `hex=7F`, `hex_on=FF`, `busy=0`, `frame_tick` never pulses.
- Full display:
  - Stimulus: at cycle 5, `load` with `data=32'h76543210`, `dig_en=8'hFF`.
  - Required: `busy=1` from cycle 6 until the boundary; `frame_tick` pulses in cycle 32 and `busy=0` from cycle 32.
  - Required from cycle 33: digit 0 shows `hex_on=FE`/`hex=1000000` for 3 cycles, then 1 guard cycle (FF/7F), then digit 1 shows FD/1111001.
  - Continuing through digit 7, which shows 7F/1111000.
- Partial mask:
  - Stimulus: `dig_en=8'h0F`, `data=32'hFEDCBA98`.
  - Required: digits 0–3 show 8, 9, A, b.
  - Required: during slots 4–7, `hex_on=FF` and `hex=7F` throughout.
- Overwrite:
  - Stimulus: load `32'h11111111` at cycle 40, then `32'h22222222` at cycle 50; both are before the boundary, so no earlier boundary intervenes.
  - Required: a single `frame_tick`; all digits then show 0100100.
- Coincident load and boundary:
  - Stimulus: `load` exactly in a boundary cycle with `pend_v=1`.
  - Required: the new data is displayed in the next frame, the old pending value never appears, and `busy=0` afterwards.
- Reset mid-operation:
  - Stimulus: assert `rst_n=0` while `busy=1` during an active slot.
  - Required: `hex_on=FF` and `hex=7F` immediately, without waiting for a clock edge.
  - Required after release: no `frame_tick` and a blank display.

Source files
------------

// File: rtl/seg7_scan_driver_if.sv
// Bus between the nibble-producing lab logic and the 7-segment scan driver.
// The producer (master) offers a 32-bit word, a digit enable mask and a load
// strobe; the driver (slave) reports its pending state and drives the display.
interface seg7_scan_driver_if;
    logic [31:0] data;
    logic [7:0]  dig_en;
    logic        load;
    logic        busy;
    logic        frame_tick;
    logic [6:0]  hex;
    logic [7:0]  hex_on;

    modport master (
        output data, dig_en, load,
        input  busy, frame_tick, hex, hex_on
    );

    modport slave (
        input  data, dig_en, load,
        output busy, frame_tick, hex, hex_on
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed driver for an 8-digit common-anode 7-segment display.
// Each digit slot lasts CLK_DIV cycles: one blank guard cycle followed by
// CLK_DIV-1 lit cycles. New values are double-buffered and only swapped in
// at the end of digit 7's slot, so a frame is never torn. The display
// outputs are registered from the next-state values, so what appears on
// hex/hex_on in a cycle always matches that cycle's slot position.
module seg7_scan_driver #(
    parameter int CLK_DIV = 100000
) (
    input  logic              clk,
    input  logic              rst_n,
    seg7_scan_driver_if.slave bus
);

    localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt, div_nxt;
    logic [2:0]       idx, idx_nxt;
    logic [31:0]      shown, shown_nxt;
    logic [7:0]       shown_en, shown_en_nxt;
    logic [31:0]      pend, pend_nxt;
    logic [7:0]       pend_en, pend_en_nxt;
    logic             pend_v, pend_v_nxt;
    logic             tick_nxt;
    logic             slot_end;
    logic             boundary;
    logic [3:0]       nibble_nxt;
    logic [6:0]       hex_nxt;
    logic [7:0]       hex_on_nxt;

    // Active-low g..a segment pattern for one hex nibble.
    function automatic logic [6:0] decode(input logic [3:0] n);
        case (n)
            4'h0:    return 7'b1000000;
            4'h1:    return 7'b1111001;
            4'h2:    return 7'b0100100;
            4'h3:    return 7'b0110000;
            4'h4:    return 7'b0011001;
            4'h5:    return 7'b0010010;
            4'h6:    return 7'b0000010;
            4'h7:    return 7'b1111000;
            4'h8:    return 7'b0000000;
            4'h9:    return 7'b0010000;
            4'hA:    return 7'b0001000;
            4'hB:    return 7'b0000011;
            4'hC:    return 7'b1000110;
            4'hD:    return 7'b0100001;
            4'hE:    return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    // Next-state for the scan counters, the two buffers and the display outputs.
    always_comb begin
        slot_end     = (div_cnt == DIV_MAX);
        boundary     = slot_end && (idx == 3'd7);
        div_nxt      = slot_end ? '0 : div_cnt + 1'b1;
        idx_nxt      = slot_end ? idx + 3'd1 : idx;
        shown_nxt    = shown;
        shown_en_nxt = shown_en;
        pend_nxt     = pend;
        pend_en_nxt  = pend_en;
        pend_v_nxt   = pend_v;
        tick_nxt     = 1'b0;

        if (boundary) begin
            if (bus.load) begin
                shown_nxt    = bus.data;
                shown_en_nxt = bus.dig_en;
                pend_v_nxt   = 1'b0;
                tick_nxt     = 1'b1;
            end else if (pend_v) begin
                shown_nxt    = pend;
                shown_en_nxt = pend_en;
                pend_v_nxt   = 1'b0;
                tick_nxt     = 1'b1;
            end
        end else if (bus.load) begin
            pend_nxt    = bus.data;
            pend_en_nxt = bus.dig_en;
            pend_v_nxt  = 1'b1;
        end

        nibble_nxt = shown_nxt[{idx_nxt, 2'b00} +: 4];
        if ((div_nxt == '0) || !shown_en_nxt[idx_nxt]) begin
            hex_on_nxt = 8'hFF;
            hex_nxt    = 7'h7F;
        end else begin
            hex_on_nxt = ~(8'h01 << idx_nxt);
            hex_nxt    = decode(nibble_nxt);
        end
    end

    // State and output registers; reset blanks the display immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt        <= '0;
            idx            <= 3'd0;
            shown          <= 32'h0;
            shown_en       <= 8'h00;
            pend           <= 32'h0;
            pend_en        <= 8'h00;
            pend_v         <= 1'b0;
            bus.frame_tick <= 1'b0;
            bus.hex        <= 7'h7F;
            bus.hex_on     <= 8'hFF;
        end else begin
            div_cnt        <= div_nxt;
            idx            <= idx_nxt;
            shown          <= shown_nxt;
            shown_en       <= shown_en_nxt;
            pend           <= pend_nxt;
            pend_en        <= pend_en_nxt;
            pend_v         <= pend_v_nxt;
            bus.frame_tick <= tick_nxt;
            bus.hex        <= hex_nxt;
            bus.hex_on     <= hex_on_nxt;
        end
    end

    assign bus.busy = pend_v;

endmodule
